uart_rx: RTL and testbench

Serial receiver matching the transmitter in the bus-attached UART: recovers 8N1 frames (start 0, 8 data bits LSB first, stop 1) from the `rx` pin. It samples on an oversampling strobe from the baud generator and holds one received byte with status flags. The bus interface reads these flags through the status register (bit 1 = rx available) and reads the byte at address 01. Single clock domain; `rx` is asynchronous and synchronized internally.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled majority-vote bit recovery
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   os_edge_i     one-cycle strobe at OVERSAMPLE x baud rate
//   rx_i          asynchronous serial line, idle high
//   read_ack_i    one-cycle pulse: consumer has taken data_o and flags
//   data_o        last good byte received
//   available_o   data_o holds an unread byte
//   framing_err_o sticky: a stop bit was sampled low
//   overrun_o     sticky: an unread byte was overwritten
//   busy_o        frame reception in progress

module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int CW         = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       os_edge_i,
    input  logic       rx_i,
    input  logic       read_ack_i,
    output logic [7:0] data_o,
    output logic       available_o,
    output logic       framing_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int M = OVERSAMPLE / 2;
    localparam logic [CW-1:0] TICK_TOP    = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] TICK_MID_LO = CW'(M - 1);
    localparam logic [CW-1:0] TICK_MID    = CW'(M);
    localparam logic [CW-1:0] TICK_MID_HI = CW'(M + 1);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    votes_q, votes_d;
    logic [7:0]    data_q, data_d;
    logic          avail_q, avail_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] tick_idx;
    logic          voted;
    logic          load;
    logic          ferr_set;

    // Two-flop synchronizer; resets to the idle-line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_ARM;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            votes_q   <= '0;
            data_q    <= '0;
            avail_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            votes_q   <= votes_d;
            data_q    <= data_d;
            avail_q   <= avail_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    // The counter runs continuously modulo OVERSAMPLE from the detection
    // tick (tick 0), so the start-bit vote and every later vote land on
    // ticks M-1..M+1 of their own bit without an explicit re-centre step.
    always_comb begin
        tick_idx = (cnt_q == TICK_TOP) ? '0 : cnt_q + CW'(1);
        voted    = (votes_q[0] & votes_q[1]) | (votes_q[0] & rx_s_q) | (votes_q[1] & rx_s_q);

        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        votes_d   = votes_q;
        load      = 1'b0;
        ferr_set  = 1'b0;

        if (os_edge_i) begin
            case (state_q)
                ST_ARM: begin
                    if (rx_s_q) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d   = ST_START;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                    end
                end
                ST_START, ST_DATA, ST_STOP: begin
                    cnt_d = tick_idx;
                    if (tick_idx == TICK_MID_LO) votes_d[0] = rx_s_q;
                    if (tick_idx == TICK_MID)    votes_d[1] = rx_s_q;
                    if (tick_idx == TICK_MID_HI) begin
                        case (state_q)
                            ST_START: state_d = voted ? ST_IDLE : ST_DATA;
                            ST_DATA: begin
                                shreg_d   = {voted, shreg_q[7:1]};
                                bit_cnt_d = bit_cnt_q + 3'd1;
                                if (bit_cnt_q == 3'd7) state_d = ST_STOP;
                            end
                            default: begin
                                if (voted) begin
                                    load    = 1'b1;
                                    state_d = ST_IDLE;
                                end else begin
                                    // Wait for the line to return high so a
                                    // held break cannot restart reception.
                                    ferr_set = 1'b1;
                                    state_d  = ST_ARM;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = ST_ARM;
            endcase
        end

        // Set events take priority over the read_ack clear.
        data_d  = load ? shreg_q : data_q;
        avail_d = load | (avail_q & ~read_ack_i);
        ferr_d  = ferr_set | (ferr_q & ~read_ack_i);
        ovr_d   = (load & avail_q & ~read_ack_i) | (ovr_q & ~read_ack_i);
        busy_d  = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    assign data_o        = data_q;
    assign available_o   = avail_q;
    assign framing_err_o = ferr_q;
    assign overrun_o     = ovr_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx

module tb_uart_rx;

    localparam int OS     = 16;
    localparam int LOAD_T = 9 * OS + OS / 2 + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       os_edge;
    logic       rx;
    logic       read_ack;
    logic [7:0] data;
    logic       available;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int passed = 0;
    int total  = 0;

    uart_rx #(.OVERSAMPLE(OS), .CW(5)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .os_edge_i    (os_edge),
        .rx_i         (rx),
        .read_ack_i   (read_ack),
        .data_o       (data),
        .available_o  (available),
        .framing_err_o(framing_err),
        .overrun_o    (overrun),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       stop_ok;
        logic       ack_after;
        logic [7:0] e_data;
        logic       e_av;
        logic       e_fe;
        logic       e_ov;
        int         e_rise;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] m_data;
    logic       m_av, m_fe, m_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // One tick period is 3 clk; rx set before the call is seen at this tick.
    task automatic do_tick(input bit ack);
        os_edge = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        os_edge  = 1'b1;
        read_ack = ack;
        @(posedge clk); #1;
        os_edge  = 1'b0;
        read_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) do_tick(1'b0);
    endtask

    task automatic ack();
        read_ack = 1'b1;
        @(posedge clk); #1;
        read_ack = 1'b0;
    endtask

    // Drives a whole frame; rise = tick index (start detection = 0) after
    // which available went 0->1, or -1.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_load,
                              output int rise);
        logic [9:0] bits;
        logic       prev;
        bits = {stop_ok, b, 1'b0};
        rise = -1;
        for (int i = 0; i < 10 * OS; i++) begin
            rx   = bits[i / OS];
            prev = available;
            do_tick(ack_load && (i == LOAD_T));
            if (rise < 0 && !prev && available) rise = i;
            if (i == 5 * OS) check("busy_mid_frame", {31'b0, busy}, 32'd1);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic av,
                             input logic fe, input logic ov);
        check({tag, "_data"}, {24'b0, data}, {24'b0, d});
        check({tag, "_avail"}, {31'b0, available}, {31'b0, av});
        check({tag, "_ferr"}, {31'b0, framing_err}, {31'b0, fe});
        check({tag, "_ovr"}, {31'b0, overrun}, {31'b0, ov});
    endtask

    initial begin
        int         rise;
        logic [9:0] bits;
        logic [7:0] b;
        bit         stop_ok, ack_load;
        int         mode;
        logic       av_before;

        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, LOAD_T};
        vecs[1] = '{8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, LOAD_T};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, -1};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, LOAD_T};
        vecs[4] = '{8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, -1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, LOAD_T};
        vecs[6] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, LOAD_T};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, -1};

        rx = 1'b1; rst = 1'b1; os_edge = 1'b0; read_ack = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        idle(4);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].b, vecs[v].stop_ok, 1'b0, rise);
            idle(4);
            check_all($sformatf("vec%0d", v), vecs[v].e_data, vecs[v].e_av, vecs[v].e_fe, vecs[v].e_ov);
            check($sformatf("vec%0d_busy", v), {31'b0, busy}, 32'd0);
            if (vecs[v].e_rise >= 0) check($sformatf("vec%0d_latency", v), rise, vecs[v].e_rise);
            if (vecs[v].ack_after) begin
                ack();
                check_all($sformatf("vec%0d_acked", v), vecs[v].e_data, 1'b0, 1'b0, 1'b0);
            end
        end

        // read_ack in the exact load cycle of the second byte
        send_frame(8'h01, 1'b1, 1'b0, rise);
        idle(2);
        send_frame(8'h02, 1'b1, 1'b1, rise);
        idle(2);
        check_all("ack_on_load", 8'h02, 1'b1, 1'b0, 1'b0);
        ack();
        check_all("ack_on_load_clr", 8'h02, 1'b0, 1'b0, 1'b0);

        // Short low glitch on an idle line
        rx = 1'b0;
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        rx = 1'b1;
        for (int i = 4; i < 9; i++) do_tick(1'b0);
        check("glitch_busy_t8", {31'b0, busy}, 32'd1);
        do_tick(1'b0);
        check("glitch_busy_t9", {31'b0, busy}, 32'd0);
        idle(10);
        check_all("glitch", 8'h02, 1'b0, 1'b0, 1'b0);

        // Framing error followed by a 40-bit-time break
        send_frame(8'h3C, 1'b0, 1'b0, rise);
        rx = 1'b0;
        repeat (40 * OS) do_tick(1'b0);
        check_all("break", 8'h02, 1'b0, 1'b1, 1'b0);
        check("break_busy", {31'b0, busy}, 32'd0);
        check("break_no_load", rise, -1);
        idle(4);
        send_frame(8'h11, 1'b1, 1'b0, rise);
        idle(2);
        check_all("after_break", 8'h11, 1'b1, 1'b1, 1'b0);
        check("after_break_latency", rise, LOAD_T);
        ack();
        check_all("after_break_clr", 8'h11, 1'b0, 1'b0, 1'b0);

        // Randomized frames against a rule-level model of the flags
        m_data = 8'h11; m_av = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
        for (int n = 0; n < 40; n++) begin
            b        = 8'($urandom_range(0, 255));
            stop_ok  = ($urandom_range(0, 5) != 0);
            mode     = $urandom_range(0, 2);
            ack_load = stop_ok && (mode == 2);
            av_before = m_av;
            send_frame(b, stop_ok, ack_load, rise);
            idle($urandom_range(1, 6));
            if (stop_ok) begin
                if (ack_load) begin
                    m_ov = 1'b0;
                    m_fe = 1'b0;
                end else begin
                    m_ov = m_ov | m_av;
                end
                m_av   = 1'b1;
                m_data = b;
            end else begin
                m_fe = 1'b1;
            end
            check_all($sformatf("rnd%0d", n), m_data, m_av, m_fe, m_ov);
            if (stop_ok && !av_before) check($sformatf("rnd%0d_latency", n), rise, LOAD_T);
            if (mode == 1) begin
                ack();
                m_av = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
                check_all($sformatf("rnd%0d_acked", n), m_data, m_av, m_fe, m_ov);
            end
        end

        // Reset in the middle of data bit 4 with the line held low
        idle(4);
        ack();
        send_frame(8'h5A, 1'b1, 1'b0, rise);
        idle(4);
        check_all("pre_reset", 8'h5A, 1'b1, 1'b0, 1'b0);
        bits = {1'b1, 8'hE5, 1'b0};
        for (int i = 0; i < 5 * OS + 5; i++) begin
            rx = bits[i / OS];
            do_tick(1'b0);
        end
        rx  = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("mid_reset_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        os_edge = 1'b1;
        @(posedge clk); #1;
        os_edge = 1'b0;
        rst = 1'b0;
        repeat (100) do_tick(1'b0);
        check_all("held_low", 8'h00, 1'b0, 1'b0, 1'b0);
        check("held_low_busy", {31'b0, busy}, 32'd0);
        idle(4);
        send_frame(8'hF0, 1'b1, 1'b0, rise);
        idle(2);
        check_all("after_reset", 8'hF0, 1'b1, 1'b0, 1'b0);
        check("after_reset_latency", rise, LOAD_T);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
